// File: rtl/hazard_ctrl.sv
// Hazard unit for a 5-stage MIPS-style pipeline: forwarding, load-use stall, branch flush,
// multi-cycle MDU stall and optional debug halt/step (enabled by defining HAZARD_DEBUG_EN).
module hazard_ctrl #(
   parameter int MDU_LAT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rs_D,
   input  logic [4:0] rt_D,
   input  logic [4:0] rs_E,
   input  logic [4:0] rt_E,
   input  logic [4:0] write_reg_E,
   input  logic       reg_write_E,
   input  logic       mem_to_reg_E,
   input  logic [4:0] write_reg_M,
   input  logic [4:0] write_reg_W,
   input  logic       reg_write_M,
   input  logic       reg_write_W,
   input  logic       pc_src_M,
   input  logic       mdu_op_D,
   input  logic       halt_req,
   input  logic       step_req,
   output logic       stall_F,
   output logic       stall_D,
   output logic       flush_D,
   output logic       flush_E,
   output logic [1:0] forward_a_E,
   output logic [1:0] forward_b_E,
   output logic       mdu_busy,
   output logic       halted,
   output logic [1:0] fsm_state
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_WAIT = 2'd1,
      HALT     = 2'd2,
      STEP     = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       busy_q, halted_q;
   logic       lw_stall;
   logic       stall_any;

   // write_reg_E/reg_write_E are not needed: Decode has no compare-in-Decode branch path.
   logic unused_inputs;
   assign unused_inputs = ^{write_reg_E, reg_write_E};

`ifndef HAZARD_DEBUG_EN
   logic unused_dbg;
   assign unused_dbg = ^{halt_req, step_req};
`endif

   always_comb begin
      forward_a_E = 2'b00;
      if (reg_write_M && (write_reg_M != 5'd0) && (write_reg_M == rs_E))
         forward_a_E = 2'b10;
      else if (reg_write_W && (write_reg_W != 5'd0) && (write_reg_W == rs_E))
         forward_a_E = 2'b01;

      forward_b_E = 2'b00;
      if (reg_write_M && (write_reg_M != 5'd0) && (write_reg_M == rt_E))
         forward_b_E = 2'b10;
      else if (reg_write_W && (write_reg_W != 5'd0) && (write_reg_W == rt_E))
         forward_b_E = 2'b01;
   end

   assign lw_stall = mem_to_reg_E && (rt_E != 5'd0) && ((rt_E == rs_D) || (rt_E == rt_D));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RUN: begin
            if (!pc_src_M) begin
               if (mdu_op_D && !lw_stall) begin
                  state_nxt = MDU_WAIT;
                  cnt_nxt   = 4'(MDU_LAT - 1);
               end
`ifdef HAZARD_DEBUG_EN
               else if (halt_req) begin
                  state_nxt = HALT;
               end
`endif
            end
         end
         MDU_WAIT: begin
            // A taken branch kills the wait; the mul/div is on the wrong path.
            if (pc_src_M || (cnt == 4'd0)) begin
               state_nxt = RUN;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
`ifdef HAZARD_DEBUG_EN
         HALT: begin
            if (!halt_req)
               state_nxt = RUN;
            else if (step_req)
               state_nxt = STEP;
         end
         STEP: begin
            if (mdu_op_D && !lw_stall && !pc_src_M) begin
               state_nxt = MDU_WAIT;
               cnt_nxt   = 4'(MDU_LAT - 1);
            end else begin
               state_nxt = HALT;
            end
         end
`endif
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         cnt      <= 4'd0;
         busy_q   <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         busy_q   <= (state_nxt == MDU_WAIT);
         halted_q <= (state_nxt == HALT);
      end
   end

   assign stall_any = lw_stall | busy_q | halted_q;

   // Reset keeps a bubble in Execute; a taken branch beats every stall source.
   always_comb begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      flush_D = 1'b0;
      flush_E = 1'b0;
      if (rst) begin
         flush_E = 1'b1;
      end else if (pc_src_M) begin
         flush_D = 1'b1;
         flush_E = 1'b1;
      end else begin
         stall_F = stall_any;
         stall_D = stall_any;
         flush_E = stall_any;
      end
   end

   assign mdu_busy  = busy_q & ~rst;
`ifdef HAZARD_DEBUG_EN
   assign halted    = halted_q & ~rst;
`else
   assign halted    = 1'b0;
`endif
   assign fsm_state = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expected output vectors go through a scoreboard queue.
module tb_hazard_ctrl;

   localparam int W = 12;
   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_HALT = 2'd2;
   localparam logic [1:0] S_STEP = 2'd3;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs_D, rt_D, rs_E, rt_E, write_reg_E, write_reg_M, write_reg_W;
   logic       reg_write_E, mem_to_reg_E, reg_write_M, reg_write_W;
   logic       pc_src_M, mdu_op_D, halt_req, step_req;
   logic       stall_F, stall_D, flush_D, flush_E, mdu_busy, halted;
   logic [1:0] forward_a_E, forward_b_E, fsm_state;

   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_mis = 0;

   hazard_ctrl #(.MDU_LAT(4)) dut (
      .clk(clk), .rst(rst),
      .rs_D(rs_D), .rt_D(rt_D), .rs_E(rs_E), .rt_E(rt_E),
      .write_reg_E(write_reg_E), .reg_write_E(reg_write_E), .mem_to_reg_E(mem_to_reg_E),
      .write_reg_M(write_reg_M), .write_reg_W(write_reg_W),
      .reg_write_M(reg_write_M), .reg_write_W(reg_write_W),
      .pc_src_M(pc_src_M), .mdu_op_D(mdu_op_D), .halt_req(halt_req), .step_req(step_req),
      .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E),
      .forward_a_E(forward_a_E), .forward_b_E(forward_b_E),
      .mdu_busy(mdu_busy), .halted(halted), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] mk(input logic sf, input logic sd, input logic fd,
                                       input logic fe, input logic [1:0] fa, input logic [1:0] fb,
                                       input logic bsy, input logic hlt, input logic [1:0] st);
      return {sf, sd, fd, fe, fa, fb, bsy, hlt, st};
   endfunction

   task automatic clr();
      {rs_D, rt_D, rs_E, rt_E, write_reg_E, write_reg_M, write_reg_W} = '0;
      {reg_write_E, mem_to_reg_E, reg_write_M, reg_write_W} = '0;
      {pc_src_M, mdu_op_D, halt_req, step_req} = '0;
   endtask

   // Advance one clock; inputs are then driven just after the falling edge.
   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic expect_now(input string tag, input logic [W-1:0] e);
      logic [W-1:0] obs, want;
      exp_q.push_back(e);
      #1;
      obs  = {stall_F, stall_D, flush_D, flush_E, forward_a_E, forward_b_E,
              mdu_busy, halted, fsm_state};
      want = exp_q.pop_front();
      n_cmp++;
      assert (obs === want) else begin
         n_mis++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, want);
      end
   endtask

   initial begin
      clr();
      rst = 1'b1;
      @(negedge clk);
      // reset with an active M->E forwarding condition
      reg_write_M = 1'b1; write_reg_M = 5'd3; rs_E = 5'd3;
      cyc();
      expect_now("reset", mk(0, 0, 0, 1, 2'b10, 2'b00, 0, 0, S_RUN));
      cyc();
      rst = 1'b0;

      // forwarding
      clr();
      reg_write_M = 1; write_reg_M = 5'd3; reg_write_W = 1; write_reg_W = 5'd3;
      rs_E = 5'd3; rt_E = 5'd3;
      expect_now("fwd_m_prio", mk(0, 0, 0, 0, 2'b10, 2'b10, 0, 0, S_RUN));
      write_reg_M = 5'd0;
      expect_now("fwd_m_zero", mk(0, 0, 0, 0, 2'b01, 2'b01, 0, 0, S_RUN));
      write_reg_M = 5'd3; reg_write_M = 0;
      expect_now("fwd_m_nowr", mk(0, 0, 0, 0, 2'b01, 2'b01, 0, 0, S_RUN));
      reg_write_W = 0;
      expect_now("fwd_none", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_RUN));
      reg_write_M = 1; reg_write_W = 1; write_reg_W = 5'd4; rt_E = 5'd4;
      expect_now("fwd_split", mk(0, 0, 0, 0, 2'b10, 2'b01, 0, 0, S_RUN));
      write_reg_W = 5'd0; rt_E = 5'd0; reg_write_M = 0;
      expect_now("fwd_w_zero", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_RUN));
      cyc();

      // load-use stall
      clr();
      mem_to_reg_E = 1; rt_E = 5'd5; rs_D = 5'd5;
      expect_now("lw_rs", mk(1, 1, 0, 1, 2'b00, 2'b00, 0, 0, S_RUN));
      cyc();
      clr();
      expect_now("lw_release", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_RUN));
      mem_to_reg_E = 1; rt_E = 5'd7; rs_D = 5'd6; rt_D = 5'd7;
      expect_now("lw_rt", mk(1, 1, 0, 1, 2'b00, 2'b00, 0, 0, S_RUN));
      rt_D = 5'd8;
      expect_now("lw_nomatch", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_RUN));
      rt_E = 5'd0; rs_D = 5'd0;
      expect_now("lw_r0", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_RUN));
      rt_E = 5'd5; rs_D = 5'd5; pc_src_M = 1;
      expect_now("lw_branch", mk(0, 0, 1, 1, 2'b00, 2'b00, 0, 0, S_RUN));
      // mdu op blocked by load-use and by branch
      mdu_op_D = 1; pc_src_M = 0;
      expect_now("mdu_lw", mk(1, 1, 0, 1, 2'b00, 2'b00, 0, 0, S_RUN));
      cyc();
      clr();
      mdu_op_D = 1; pc_src_M = 1;
      expect_now("mdu_br", mk(0, 0, 1, 1, 2'b00, 2'b00, 0, 0, S_RUN));
      cyc();
      clr();
      expect_now("mdu_blocked", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_RUN));

      // full MDU wait
      mdu_op_D = 1;
      expect_now("mdu_issue", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_RUN));
      cyc();
      mdu_op_D = 0;
      for (int i = 0; i < 4; i++) begin
         expect_now($sformatf("mdu_wait%0d", i), mk(1, 1, 0, 1, 2'b00, 2'b00, 1, 0, S_WAIT));
         cyc();
      end
      expect_now("mdu_done", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_RUN));

      // branch aborts MDU wait in its 2nd cycle
      mdu_op_D = 1;
      cyc();
      mdu_op_D = 0;
      expect_now("abort_w1", mk(1, 1, 0, 1, 2'b00, 2'b00, 1, 0, S_WAIT));
      cyc();
      pc_src_M = 1;
      expect_now("abort_w2", mk(0, 0, 1, 1, 2'b00, 2'b00, 1, 0, S_WAIT));
      cyc();
      pc_src_M = 0;
      expect_now("abort_after", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_RUN));

      // reset in MDU wait with counter = 2
      mdu_op_D = 1;
      cyc();
      mdu_op_D = 0;
      cyc();
      rst = 1;
      expect_now("rst_in_wait", mk(0, 0, 0, 1, 2'b00, 2'b00, 0, 0, S_WAIT));
      cyc();
      rst = 0;
      expect_now("rst_after", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_RUN));
      cyc();
      expect_now("rst_after2", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_RUN));

`ifdef HAZARD_DEBUG_EN
      halt_req = 1;
      expect_now("halt_req", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_RUN));
      cyc();
      expect_now("halt1", mk(1, 1, 0, 1, 2'b00, 2'b00, 0, 1, S_HALT));
      cyc();
      step_req = 1;
      expect_now("halt_step_req", mk(1, 1, 0, 1, 2'b00, 2'b00, 0, 1, S_HALT));
      cyc();
      step_req = 0;
      expect_now("step", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_STEP));
      cyc();
      expect_now("halt_again", mk(1, 1, 0, 1, 2'b00, 2'b00, 0, 1, S_HALT));
      pc_src_M = 1;
      expect_now("halt_branch", mk(0, 0, 1, 1, 2'b00, 2'b00, 0, 1, S_HALT));
      cyc();
      pc_src_M = 0; halt_req = 0; step_req = 1;
      expect_now("unhalt", mk(1, 1, 0, 1, 2'b00, 2'b00, 0, 1, S_HALT));
      cyc();
      step_req = 0;
      expect_now("resumed", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_RUN));
`else
      halt_req = 1; step_req = 1;
      cyc();
      expect_now("halt_ignored", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_RUN));
      cyc();
      expect_now("halt_ignored2", mk(0, 0, 0, 0, 2'b00, 2'b00, 0, 0, S_RUN));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
